apb_master: RTL
===============

Name: apb_master

Overview:
- APB initiator that the processor-side logic uses to drive the peripheral bus shared by the UART and GPIO slaves.
- Accepts one command at a time on a valid/ready request port, then runs a standard SETUP→ACCESS APB transfer.
- Waits for pready and returns read data and error status on a one-cycle response strobe.

Parameters:
- ADDR_W, 32, width of pAdd and cmd_addr
- DATA_W, 32, width of pwData, prdata, cmd_wdata, rsp_rdata
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without pready before abort (only used with APB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_sel  in  2  slave select code (2'b10 UART, 2'b01 GPIO)
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (0 for writes)
- rsp_err  out  1  error flag, valid with rsp_valid
- busy  out  1  high from command accept until rsp_valid
- pAdd  out  ADDR_W  APB address
- pwData  out  DATA_W  APB write data
- psel  out  2  APB select
- pen  out  1  APB enable
- pwr  out  1  APB write
- prdata  in  DATA_W  APB read data
- pready  in  1  APB slave ready
- perr  in  1  APB slave error, sampled with pready

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE; every output is 0 except cmd_ready=1. The cmd_ready=1 value takes effect on the first edge after reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1, psel=0, pen=0.
  - On cmd_valid with a legal cmd_sel (10 or 01): latch cmd_* into registers, busy=1, go to SETUP.
  - On an illegal cmd_sel (00 or 11): no bus cycle; go to RESP with rsp_err=1 and rsp_rdata=0.
- SETUP (exactly 1 cycle):
  - Drive psel=latched sel, pAdd, pwr=cmd_write, pwData (0 on reads); pen=0; cmd_ready=0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - pen=1; psel, pAdd, pwr, pwData held stable.
  - Stay until pready=1. On the pready cycle, capture rsp_rdata=prdata on reads (0 on writes) and rsp_err=perr; go to RESP.
- RESP (1 cycle):
  - rsp_valid=1; psel=0, pen=0, busy=0.
  - Go to IDLE. cmd_ready returns high in IDLE, so there are no back-to-back transfers and always at least one idle bus cycle between transfers.
- Latency: minimum transfer is accept edge → SETUP → ACCESS(pready) → RESP, so rsp_valid rises 3 cycles after the accept edge. Each pready wait cycle adds 1.
- pready outside ACCESS is ignored; perr is ignored unless pready=1.
- cmd_* inputs are ignored while busy. Changing them mid-transfer has no effect on the bus.
- rsp_rdata and rsp_err hold their value until the next RESP.
- Reset asserted mid-transfer aborts immediately: bus outputs go to 0 on that edge and no rsp_valid is issued.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on SETUP and increments each ACCESS cycle while pready=0.
  - When the count reaches TIMEOUT_CYCLES, the transfer aborts: go to RESP with rsp_err=1 and rsp_rdata=0, and drop pen/psel.
  - pready on the same cycle as the timeout wins (normal completion).
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Shared package apb_pkg:
  - state enum encodings (IDLE, SETUP, ACCESS, RESP)
  - select constants SEL_UART=2'b10, SEL_GPIO=2'b01, SEL_NONE=2'b00
  - default ADDR_W and DATA_W
- One natural sub-module: apb_timeout_cnt (counter with clear, enable and terminal-count flag), instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Reset then write: cmd_write=1, sel=10, addr=0x10, wdata=0xA5A5_1234, pready held 1 → SETUP 1 cycle (pen=0), ACCESS 1 cycle (pen=1, pwData=0xA5A5_1234); rsp_valid 3 cycles after accept, rsp_err=0.
- Read with wait states: sel=01, pready low for 4 ACCESS cycles, then high with prdata=0xDEAD_BEEF → pen stays 1 for 5 cycles with addr stable; rsp_rdata=0xDEAD_BEEF.
- Illegal select: cmd_valid with sel=11 → psel never leaves 0; rsp_valid with rsp_err=1 one cycle after accept.
- Slave error plus stray signals: perr=1 with pready=1 → rsp_err=1. perr=1 and pready=1 asserted while in IDLE → no effect.
- Reset mid-ACCESS: assert rst_n=0 during a wait state → next edge psel=0, pen=0, busy=0; no rsp_valid.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=8): pready held 0 → abort after 8 ACCESS cycles with rsp_err=1. Repeat with pready=1 on cycle 8 → normal completion, rsp_err=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM state encodings,
// slave-select codes and default bus widths.
package apb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] SEL_UART = 2'b10;
  localparam logic [1:0] SEL_GPIO = 2'b01;
  localparam logic [1:0] SEL_NONE = 2'b00;

  // Only one-hot codes address a real slave; 00 and 11 are rejected.
  function automatic logic sel_legal(input logic [1:0] sel);
    return (sel == SEL_UART) || (sel == SEL_GPIO);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB initiator's ACCESS timeout.
// tc flags the cycle on which the count would reach TC_VALUE, so the
// abort decision lands on the same edge the count hits the limit.
module apb_timeout_cnt #(
  parameter int unsigned TC_VALUE = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = $clog2(TC_VALUE + 1);

  logic [CNT_W-1:0] count;

  // Count wait cycles; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(TC_VALUE - 1));

endmodule

// File: rtl/apb_master.sv
// APB initiator: single outstanding command, SETUP -> ACCESS -> RESP.
// Optional ACCESS timeout is compiled in with APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a command, bus parked
// SETUP  | psel/address/direction/data driven, pen low
// ACCESS | pen high, waiting for pready
// RESP   | one-cycle rsp_valid strobe, bus released
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [1:0]        cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] pAdd,
  output logic [DATA_W-1:0] pwData,
  output logic [1:0]        psel,
  output logic              pen,
  output logic              pwr,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              perr
);

  logic [1:0] state;
  logic       abort;

`ifdef APB_TIMEOUT_EN
  logic tc;

  apb_timeout_cnt #(
    .TC_VALUE(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_SETUP),
    .en    ((state == ST_ACCESS) && !pready),
    .tc    (tc)
  );

  // A slave answering on the limit cycle still completes normally.
  assign abort = tc && !pready;
`else
  // Without the timeout ACCESS waits for pready forever; the parameter
  // stays on the interface so both builds share one instantiation.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign abort          = 1'b0;
`endif

  assign cmd_ready = (state == ST_IDLE);

  // Transfer sequencer; all bus and response outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      pAdd      <= '0;
      pwData    <= '0;
      psel      <= SEL_NONE;
      pen       <= 1'b0;
      pwr       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (sel_legal(cmd_sel)) begin
              state  <= ST_SETUP;
              busy   <= 1'b1;
              psel   <= cmd_sel;
              pAdd   <= cmd_addr;
              pwr    <= cmd_write;
              pwData <= cmd_write ? cmd_wdata : '0;
            end else begin
              // No slave decodes this select: answer with an error, no bus cycle.
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
          pen   <= 1'b1;
        end
        ST_ACCESS: begin
          if (pready) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= pwr ? '0 : prdata;
            rsp_err   <= perr;
            psel      <= SEL_NONE;
            pen       <= 1'b0;
            busy      <= 1'b0;
          end else if (abort) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= SEL_NONE;
            pen       <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
